// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for divided-clock monitors
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_WAIT_RISE,
    MON_MEASURE
  } mon_state_e;

endpackage

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - synchronizer for an asynchronous level plus rising-edge detect
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], sig_in};
      s_d   <= chain[SYNC_STAGES-1];
    end
  end

  // Edge is combinational on the synchronized level so the consumer registers it once.
  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/clock_ratio_monitor.sv
// rtl/clock_ratio_monitor.sv - measures period and high time of a divided clock against an expected ratio
module clock_ratio_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam int               LW        = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0]    LOCK_MAX  = LW'(LOCK_CNT);
  localparam logic [LW-1:0]    LOCK_PRE  = LW'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DUTY_TOL  = (CNT_W + 1)'(1);

  mon_state_e       state, state_next;
  logic             s, rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [LW-1:0]    lock_cnt;

  logic [CNT_W:0]   hi_x2, exp_x, duty_diff;
  logic             period_ok, duty_ok, good;
  logic             meas_rise, timeout, err_set;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise)
  );

  // Duty is judged as |2*high - period| so odd ratios accept either rounding of the half period.
  always_comb begin
    hi_x2     = {hi_cnt, 1'b0};
    exp_x     = {1'b0, exp_period};
    duty_diff = (hi_x2 >= exp_x) ? (hi_x2 - exp_x) : (exp_x - hi_x2);
    period_ok = (per_cnt == exp_period) && (|exp_period[CNT_W-1:1]);
    duty_ok   = (duty_diff <= DUTY_TOL);
    good      = period_ok && duty_ok;
  end

  always_comb begin
    meas_rise = en && (state == MON_MEASURE) && rise;
    timeout   = en && (state == MON_MEASURE) && !rise && (per_cnt == CNT_MAX);
    err_set   = (meas_rise && !good) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MON_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = MON_IDLE;
    end else begin
      case (state)
        MON_IDLE:      state_next = MON_WAIT_RISE;
        MON_WAIT_RISE: if (rise) state_next = MON_MEASURE;
        MON_MEASURE:   if (timeout) state_next = MON_WAIT_RISE;
        default:       state_next = MON_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        per_cnt  <= '0;
        hi_cnt   <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          MON_WAIT_RISE: begin
            if (rise) begin
              per_cnt <= CNT_ONE;
              hi_cnt  <= CNT_ONE;
            end
          end
          MON_MEASURE: begin
            if (rise) begin
              period     <= per_cnt;
              high_time  <= hi_cnt;
              meas_valid <= 1'b1;
              per_cnt    <= CNT_ONE;
              hi_cnt     <= CNT_ONE;
              if (good) begin
                if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LW'(1);
                if (lock_cnt >= LOCK_PRE) locked <= 1'b1;
              end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
              end
            end else if (per_cnt == CNT_MAX) begin
              per_cnt  <= '0;
              hi_cnt   <= '0;
              lock_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              per_cnt <= per_cnt + CNT_ONE;
              if (s) hi_cnt <= hi_cnt + CNT_ONE;
            end
          end
          default: begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            lock_cnt <= '0;
          end
        endcase
      end
    end
  end

  // A fresh error in the same cycle as a clear must survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// tb/tb_clock_ratio_monitor.sv - directed self-checking bench for clock_ratio_monitor
`timescale 1ns/1ps
module tb_clock_ratio_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sig_in;
  logic [7:0] exp_period;
  logic       err_clr;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       meas_valid;
  logic       locked;
  logic       err;

  int pass_cnt = 0;
  int total    = 0;
  bit gen_on   = 1'b0;
  int gen_hi   = 4;
  int gen_lo   = 4;
  bit saw_meas;

  clock_ratio_monitor #(
    .CNT_W       (8),
    .SYNC_STAGES (2),
    .LOCK_CNT    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sig_in     (sig_in),
    .exp_period (exp_period),
    .err_clr    (err_clr),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divided-clock source; half-cycle resolution, edges offset 2 ns from clk edges.
  initial begin
    #2;
    forever begin
      if (gen_on) begin
        sig_in = 1'b1;
        #(gen_hi * 5);
        sig_in = 1'b0;
        #(gen_lo * 5);
      end else begin
        #5;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_meas();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < 60);
    chk("meas_arrival", 32'(meas_valid), 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sig_in = 1'b0; err_clr = 1'b0; exp_period = 8'd4;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period), 0);
    chk("rst_high", 32'(high_time), 0);
    chk("rst_valid", 32'(meas_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // /4, 2 high 2 low
    en = 1'b1; gen_hi = 4; gen_lo = 4; gen_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_meas();
      chk("div4_period", 32'(period), 4);
      chk("div4_high", 32'(high_time), 2);
      if (i == 2) chk("div4_not_locked_3rd", 32'(locked), 0);
      if (i == 3) chk("div4_locked_4th", 32'(locked), 1);
    end
    @(negedge clk);
    chk("div4_valid_pulse", 32'(meas_valid), 0);
    chk("div4_err", 32'(err), 0);

    // en low: results and err hold, lock drops
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_low_locked", 32'(locked), 0);
    chk("en_low_period_hold", 32'(period), 4);
    chk("en_low_high_hold", 32'(high_time), 2);
    chk("en_low_err", 32'(err), 0);

    // /3, 1.5 clk high
    gen_hi = 3; gen_lo = 3; exp_period = 8'd3;
    repeat (10) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_meas();
      chk("div3_period", 32'(period), 3);
      chk("div3_high_1or2", 32'(high_time == 8'd1 || high_time == 8'd2), 1);
      if (i == 2) chk("div3_not_locked_3rd", 32'(locked), 0);
      if (i == 3) chk("div3_locked_4th", 32'(locked), 1);
    end
    chk("div3_err", 32'(err), 0);

    // locked /4 then switch source to /5
    en = 1'b0; gen_hi = 4; gen_lo = 4; exp_period = 8'd4;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (4) wait_meas();
    chk("relock_div4", 32'(locked), 1);
    gen_hi = 5; gen_lo = 5;
    wait_meas();
    chk("last_div4_period", 32'(period), 4);
    chk("last_div4_locked", 32'(locked), 1);
    wait_meas();
    chk("div5_period", 32'(period), 5);
    chk("div5_err", 32'(err), 1);
    chk("div5_unlocked", 32'(locked), 0);
    err_clr = 1'b1; exp_period = 8'd5;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      wait_meas();
      chk("div5_good_period", 32'(period), 5);
      if (i == 2) chk("div5_not_locked_3rd", 32'(locked), 0);
      if (i == 3) chk("div5_locked_4th", 32'(locked), 1);
    end
    chk("div5_good_err", 32'(err), 0);

    // err_clr coincident with a bad measurement
    exp_period = 8'd4;
    repeat (4) @(negedge clk);
    chk("pre_coincide_err", 32'(err), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("coincide_valid", 32'(meas_valid), 1);
    chk("coincide_err_wins", 32'(err), 1);
    @(negedge clk);
    chk("coincide_err_sticky", 32'(err), 1);
    chk("coincide_unlocked", 32'(locked), 0);

    // quiet the source, restart from WAIT_RISE under manual control
    gen_on = 1'b0;
    repeat (20) @(negedge clk);
    en = 1'b0; err_clr = 1'b1; exp_period = 8'd4;
    @(negedge clk);
    err_clr = 1'b0; en = 1'b1;
    @(negedge clk);
    #2 sig_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 sig_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("first_rise_no_meas", 32'(meas_valid), 0);
    #2 sig_in = 1'b1;
    @(negedge clk);
    chk("latency_k", 32'(meas_valid), 0);
    @(negedge clk);
    chk("latency_k1", 32'(meas_valid), 0);
    @(negedge clk);
    chk("latency_k2", 32'(meas_valid), 1);
    chk("manual_period", 32'(period), 4);
    chk("manual_high", 32'(high_time), 2);

    // timeout: per_cnt starts at 1 on that edge and saturates 254 edges later
    #2 sig_in = 1'b0;
    saw_meas = 1'b0;
    for (int i = 0; i < 254; i++) begin
      @(negedge clk);
      if (meas_valid) saw_meas = 1'b1;
    end
    chk("timeout_edge_minus1_err", 32'(err), 0);
    @(negedge clk);
    if (meas_valid) saw_meas = 1'b1;
    chk("timeout_err", 32'(err), 1);
    chk("timeout_no_meas", 32'(saw_meas), 0);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_period_hold", 32'(period), 4);

    // after timeout a single rise must not produce a measurement
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout_err_clr", 32'(err), 0);
    #2 sig_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 sig_in = 1'b0;
    saw_meas = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (meas_valid) saw_meas = 1'b1;
    end
    chk("post_timeout_one_rise", 32'(saw_meas), 0);
    #2 sig_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_timeout_second_rise", 32'(meas_valid), 1);
    chk("post_timeout_period", 32'(period), 10);
    chk("post_timeout_high", 32'(high_time), 2);
    chk("post_timeout_bad_err", 32'(err), 1);

    // en low mid-MEASURE
    en = 1'b0;
    @(negedge clk);
    chk("en_mid_period_hold", 32'(period), 10);
    chk("en_mid_err_hold", 32'(err), 1);
    chk("en_mid_locked", 32'(locked), 0);
    #2 sig_in = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    gen_hi = 4; gen_lo = 4; gen_on = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_meas();
      chk("reenable_period", 32'(period), 4);
      if (i == 3) chk("reenable_locked", 32'(locked), 1);
    end
    chk("reenable_err", 32'(err), 0);

    // asynchronous reset mid-MEASURE
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period), 0);
    chk("arst_high", 32'(high_time), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_valid", 32'(meas_valid), 0);
    gen_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
